// File: rtl/flex_counter_sync_pkg.sv
// Shared sizing for flex_counter_sync and for blocks that size their own
// instances from the same default width.
package flex_counter_sync_pkg;
  localparam int unsigned FLEX_CNT_BITS = 4;
endpackage

// File: rtl/flex_counter_sync.sv
// Up-counter 1..rollover_val with a registered rollover flag.
// The next-state logic is combinational and feeds a single register stage.
module flex_counter_sync
  import flex_counter_sync_pkg::*;
#(
  parameter int unsigned NUM_CNT_BITS = FLEX_CNT_BITS
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    clear,
  input  logic                    count_enable,
  input  logic [NUM_CNT_BITS-1:0] rollover_val,
  output logic [NUM_CNT_BITS-1:0] count_out,
  output logic                    rollover_flag
);

  logic [NUM_CNT_BITS-1:0] nxt_cnt;
  logic                    nxt_flag;

  // The terminal compare happens before the increment, so R = 2^N-1 cannot
  // overflow. A count above a lowered R wraps through 0 naturally.
  always_comb begin
    nxt_cnt  = count_out;
    nxt_flag = 1'b0;
    if (clear) begin
      nxt_cnt  = '0;
      nxt_flag = 1'b0;
    end else begin
      if (count_enable) begin
        if (count_out == rollover_val) nxt_cnt = NUM_CNT_BITS'(1);
        else                           nxt_cnt = count_out + NUM_CNT_BITS'(1);
      end
      nxt_flag = (nxt_cnt == rollover_val);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_out     <= '0;
      rollover_flag <= 1'b0;
    end else begin
      count_out     <= nxt_cnt;
      rollover_flag <= nxt_flag;
    end
  end

endmodule

// File: tb/tb_flex_counter_sync.sv
// Directed bench for flex_counter_sync (N=4): hand-computed count/flag
// values checked one step after each rising edge.
module tb_flex_counter_sync;
  localparam int N = 4;

  logic         clk = 1'b0;
  logic         rst, clear, count_enable;
  logic [N-1:0] rollover_val;
  logic [N-1:0] count_out;
  logic         rollover_flag;

  int n_pass = 0;
  int n_tot  = 0;

  flex_counter_sync #(.NUM_CNT_BITS(N)) dut (
    .clk          (clk),
    .rst          (rst),
    .clear        (clear),
    .count_enable (count_enable),
    .rollover_val (rollover_val),
    .count_out    (count_out),
    .rollover_flag(rollover_flag)
  );

  always #5 clk = ~clk;

  // Advance n rising edges; inputs are driven and outputs sampled 1 time unit after.
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [N-1:0] exp_cnt, input logic exp_flag);
    n_tot++;
    assert ({count_out, rollover_flag} === {exp_cnt, exp_flag}) n_pass++;
    else $error("FAIL %s: count=%0d flag=%0b, expected count=%0d flag=%0b",
                tag, count_out, rollover_flag, exp_cnt, exp_flag);
  endtask

  initial begin
    rst = 1'b1; clear = 1'b0; count_enable = 1'b0; rollover_val = 4'd2;
    step(1); check("reset", 4'd0, 1'b0);

    // basic increment, R=2
    rst = 1'b0; count_enable = 1'b1;
    step(1); check("inc1", 4'd1, 1'b0);
    step(1); check("inc2", 4'd2, 1'b1);
    step(1); check("inc_wrap", 4'd1, 1'b0);

    // reset mid-count
    rst = 1'b1;
    step(1); check("rst_mid", 4'd0, 1'b0);
    rst = 1'b0;
    step(1); check("rst_rel1", 4'd1, 1'b0);
    step(1); check("rst_rel2", 4'd2, 1'b1);

    // clear beats enable
    clear = 1'b1;
    step(1); check("clr_en", 4'd0, 1'b0);
    clear = 1'b0;
    step(1); check("clr_rel", 4'd1, 1'b0);

    // reset beats clear and enable
    clear = 1'b1; rst = 1'b1;
    step(1); check("rst_over_clr", 4'd0, 1'b0);
    rst = 1'b0; clear = 1'b0;

    // max rollover R=15, starting from 0
    rollover_val = 4'd15;
    step(14); check("max14", 4'd14, 1'b0);
    step(1);  check("max15", 4'd15, 1'b1);
    step(1);  check("max_wrap", 4'd1, 1'b0);
    step(14); check("max15b", 4'd15, 1'b1);

    // hold at terminal
    count_enable = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step(1); check("hold_term", 4'd15, 1'b1);
    end
    count_enable = 1'b1;
    step(1); check("hold_rel", 4'd1, 1'b0);

    // dynamic rollover change while idle
    rollover_val = 4'd10;
    step(4); check("dyn_cnt5", 4'd5, 1'b0);
    count_enable = 1'b0;
    step(1); check("dyn_idle", 4'd5, 1'b0);
    rollover_val = 4'd5;
    step(1); check("dyn_flag", 4'd5, 1'b1);
    count_enable = 1'b1;
    step(1); check("dyn_roll", 4'd1, 1'b0);

    // lower R below current count: run through 15, wrap to 0, then reach R
    rollover_val = 4'd10;
    step(5); check("low_cnt6", 4'd6, 1'b0);
    rollover_val = 4'd3;
    step(1); check("low_7", 4'd7, 1'b0);
    step(8); check("low_15", 4'd15, 1'b0);
    step(1); check("low_wrap0", 4'd0, 1'b0);
    step(3); check("low_hit3", 4'd3, 1'b1);
    step(1); check("low_roll", 4'd1, 1'b0);

    // R=0: natural wrap, flag in the 0 state, then 1
    rollover_val = 4'd0;
    step(14); check("zero_15", 4'd15, 1'b0);
    step(1);  check("zero_0", 4'd0, 1'b1);
    step(1);  check("zero_1", 4'd1, 1'b0);

    // clear while idle at a terminal value
    rollover_val = 4'd1; count_enable = 1'b0;
    step(1); check("idle_flag", 4'd1, 1'b1);
    clear = 1'b1;
    step(1); check("clr_idle", 4'd0, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end
endmodule
